// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for mem_port_arbiter: index widths, the load tag
// and packed-bus slice extraction.
package mem_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int LD_IDX_W = $clog2(MAX_REQ);
  localparam int ST_IDX_W = $clog2(MAX_REQ);
  localparam int BUS_MAX  = 512;

  typedef logic [LD_IDX_W-1:0] ld_tag_t;

  // Caller zero-extends the bus to BUS_MAX and truncates the result to w bits.
  function automatic logic [63:0] get_slice(input logic [BUS_MAX-1:0] bus,
                                            input int idx, input int w);
    logic [BUS_MAX-1:0] sh;
    sh = bus >> (idx * w);
    return sh[63:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: request vector to one-hot grant, search starts one past
// the last accepted index; the pointer moves only when accept is high.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = LD_IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;

  always_comb begin
    int  j;
    logic found;
    j         = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ptr <= IW'(N - 1);
    else if (accept) ptr <= grant_idx;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one BRAM port pair between load and store requesters with a
// credit-bounded in-order load response FIFO. MEM_ARB_HAZARD_EN enables RAW hazard stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_LD     = 2,
  parameter int NUM_ST     = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int RESP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_LD-1:0]            ld_req_valid,
  input  logic [NUM_LD*ADDR_WIDTH-1:0] ld_req_addr,
  output logic [NUM_LD-1:0]            ld_req_ready,
  output logic [NUM_LD-1:0]            ld_resp_valid,
  output logic [DATA_WIDTH-1:0]        ld_resp_data,
  input  logic [NUM_LD-1:0]            ld_resp_ready,
  input  logic [NUM_ST-1:0]            st_req_valid,
  input  logic [NUM_ST*ADDR_WIDTH-1:0] st_req_addr,
  input  logic [NUM_ST*DATA_WIDTH-1:0] st_req_data,
  output logic [NUM_ST-1:0]            st_req_ready,
  output logic                         loadEn,
  output logic [ADDR_WIDTH-1:0]        loadAddr,
  input  logic [DATA_WIDTH-1:0]        loadData,
  output logic                         storeEn,
  output logic [ADDR_WIDTH-1:0]        storeAddr,
  output logic [DATA_WIDTH-1:0]        storeData
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [NUM_LD-1:0]     ld_cand;
  ld_tag_t               ld_idx;
  logic [ST_IDX_W-1:0]   st_idx;
  logic [ADDR_WIDTH-1:0] ld_win_addr, st_win_addr;
  logic [DATA_WIDTH-1:0] st_win_data;
  logic                  hazard, credit_ok, pop, head_rdy, ld_accept, st_accept;

  logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
  ld_tag_t               fifo_tag  [RESP_DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         fifo_cnt, outstanding;
  ld_tag_t               tag_s0, tag_s1;
  logic                  vld_s1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_LD), .IW(LD_IDX_W)) u_ld_arb (
    .clk(clk), .rst(rst), .req(ld_req_valid), .accept(ld_accept),
    .grant(ld_cand), .grant_idx(ld_idx)
  );

  rr_arbiter #(.N(NUM_ST), .IW(ST_IDX_W)) u_st_arb (
    .clk(clk), .rst(rst), .req(st_req_valid), .accept(st_accept),
    .grant(st_req_ready), .grant_idx(st_idx)
  );

  assign ld_win_addr = ADDR_WIDTH'(get_slice(BUS_MAX'(ld_req_addr), int'(ld_idx), ADDR_WIDTH));
  assign st_win_addr = ADDR_WIDTH'(get_slice(BUS_MAX'(st_req_addr), int'(st_idx), ADDR_WIDTH));
  assign st_win_data = DATA_WIDTH'(get_slice(BUS_MAX'(st_req_data), int'(st_idx), DATA_WIDTH));

`ifdef MEM_ARB_HAZARD_EN
  // Hold the load back so it reads behind the same-address store.
  assign hazard = (|ld_req_valid) && (|st_req_valid) && (ld_win_addr == st_win_addr);
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    head_rdy      = 1'b0;
    ld_resp_valid = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      if (fifo_tag[head] == ld_tag_t'(i)) begin
        head_rdy         = ld_resp_ready[i];
        ld_resp_valid[i] = (fifo_cnt != '0);
      end
    end
  end

  assign ld_resp_data = fifo_data[head];
  assign pop          = (fifo_cnt != '0) && head_rdy;
  assign credit_ok    = (outstanding < CW'(RESP_DEPTH)) || pop;
  assign ld_req_ready = ld_cand & {NUM_LD{credit_ok && !hazard}};
  assign ld_accept    = |ld_req_ready;
  assign st_accept    = |st_req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loadEn      <= 1'b0;
      loadAddr    <= '0;
      storeEn     <= 1'b0;
      storeAddr   <= '0;
      storeData   <= '0;
      tag_s0      <= '0;
      tag_s1      <= '0;
      vld_s1      <= 1'b0;
      head        <= '0;
      tail        <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
      end
    end else begin
      loadEn  <= ld_accept;
      storeEn <= st_accept;
      if (ld_accept) begin
        loadAddr <= ld_win_addr;
        tag_s0   <= ld_idx;
      end
      if (st_accept) begin
        storeAddr <= st_win_addr;
        storeData <= st_win_data;
      end
      // loadData is valid the cycle after loadEn, aligned with stage 1.
      tag_s1 <= tag_s0;
      vld_s1 <= loadEn;
      if (vld_s1) begin
        fifo_data[tail] <= loadData;
        fifo_tag[tail]  <= tag_s1;
        tail            <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      if (vld_s1 && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!vld_s1 && pop) fifo_cnt <= fifo_cnt - CW'(1);
      if (ld_accept && !pop)      outstanding <= outstanding + CW'(1);
      else if (!ld_accept && pop) outstanding <= outstanding - CW'(1);
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one BRAM-style memory interface between NUM_LD load requesters and NUM_ST store requesters, each with its own valid/ready handshake.
- Drives the loadEn/loadAddr/storeEn/storeAddr/storeData/loadData interface of the mem_to_bram converter. Sits between the dataflow kernel's memory ports and that converter.
- Round-robin arbitration, with a credit-bounded in-order load response FIFO.

## Interface
- NUM_LD, 2, number of load requesters (1..8)
- NUM_ST, 2, number of store requesters (1..8)
- DATA_WIDTH, 8, data width
- ADDR_WIDTH, 7, address width
- RESP_DEPTH, 4, load response FIFO depth and credit limit (>=1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ld_req_valid  in  NUM_LD  load request per requester
- ld_req_addr  in  NUM_LD*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ld_req_ready  out  NUM_LD  one-hot grant
- ld_resp_valid  out  NUM_LD  one-hot to the owner of the FIFO head
- ld_resp_data  out  DATA_WIDTH  FIFO head data
- ld_resp_ready  in  NUM_LD  per-requester response acceptance
- st_req_valid  in  NUM_ST  store request per requester
- st_req_addr  in  NUM_ST*ADDR_WIDTH  packed store addresses
- st_req_data  in  NUM_ST*DATA_WIDTH  packed store data
- st_req_ready  out  NUM_ST  one-hot grant
- loadEn  out  1  memory read enable
- loadAddr  out  ADDR_WIDTH  memory read address
- loadData  in  DATA_WIDTH  read data, valid the cycle after loadEn
- storeEn  out  1  memory write enable
- storeAddr  out  ADDR_WIDTH  memory write address
- storeData  out  DATA_WIDTH  memory write data

## Operation
- **Load arbitration:** round-robin over ld_req_valid. Priority starts at the index after the last accepted requester. The pointer updates only on accept.
- **Load grant:** at most one ld_req_ready bit high per cycle. A grant requires a credit: outstanding < RESP_DEPTH, or a response pops this cycle.
- **Outstanding count:** number of loads accepted and not yet popped. +1 on accept, -1 on pop, both allowed in the same cycle.
- **Load issue:** an accepted load registers loadEn=1 and loadAddr, together with the owner index into a 2-stage tag pipeline. loadData is written into the FIFO with its tag one cycle after loadEn.
- **Responses:** returned strictly in issue order. Head-of-line blocking is accepted.
  - ld_resp_valid[owner]=1 while the FIFO is non-empty.
  - Pop when ld_resp_ready[owner]=1. ready bits of non-owners are ignored.
- **Store path:** independent round-robin over st_req_valid. No backpressure from memory, so every cycle with any valid grants exactly one store. The accepted store registers storeEn=1, storeAddr and storeData.
- ld_req_ready and st_req_ready are combinational from the valids, pointers, credit and hazard logic. They never depend on the same requester's ready.
- **Reset** (rst=0, asynchronous):
  - loadEn, storeEn, loadAddr, storeAddr, storeData = 0.
  - ld_resp_valid = 0, FIFO empty, outstanding = 0, tag pipeline cleared.
  - Both round-robin pointers = N-1, so requester 0 has first priority.
  - A mid-operation reset discards all in-flight loads and their responses.

## Timing
- Load accepted in cycle t: loadEn high in t+1, loadData sampled at end of t+2, ld_resp_valid from t+3 (FIFO was empty and no hazard).
- Store accepted in cycle t: storeEn high in t+1, for exactly one cycle per store.
- **Throughput:** 1 load/cycle sustained when RESP_DEPTH>=3 and responses are popped immediately. With RESP_DEPTH<3, load throughput is RESP_DEPTH loads per 3 cycles.
- A load and a store may both issue in the same cycle.

## Configuration
- Macro MEM_ARB_HAZARD_EN.
- **Defined:** if the load and store winners in a cycle have equal addresses, the load grant is suppressed for that cycle and the load pointer is unchanged. The store proceeds, and the load issues after it, so it reads the new data.
- **Undefined:** no comparison. Both issue in the same cycle and the load returns the memory's native same-cycle read/write value.

## Structure
- Package mem_arb_pkg holds:
  - localparam helpers: clog2-based index widths LD_IDX_W and ST_IDX_W;
  - typedef for the load tag (owner index);
  - the function that unpacks a slice from a packed bus.
- Sub-module rr_arbiter (parameter N) provides request vector → one-hot grant, plus a pointer update on an accept input. It is instantiated once for loads and once for stores.
- The response FIFO is inline: register array with head and tail pointers that wrap modulo RESP_DEPTH.

## Test plan
- **Single load:** reset, ld_req_valid=01, addr0=0x05, memory[5]=0xA3 → loadEn at t+1 with loadAddr=5; ld_resp_valid=01 and ld_resp_data=0xA3 at t+3.
- **Load fairness:** both load requesters valid continuously with responses always accepted → grants alternate 0,1,0,1; 1 load/cycle with RESP_DEPTH=4.
- **Credit stall:** ld_resp_ready=0 with RESP_DEPTH=4 → exactly 4 loads accepted, then ld_req_ready=0. Release ready → responses arrive in issue order with correct owners.
- **Store fairness:** st_req_valid=11 for 4 cycles with data 0x11/0x22 → storeEn high 4 consecutive cycles, storeData alternating 0x11, 0x22, 0x11, 0x22.
- **Hazard:** same-cycle load and store to address 0x10 (old value 0x00, new value 0x7F):
  - with MEM_ARB_HAZARD_EN, the load is delayed one cycle and returns 0x7F;
  - without it, the load issues together with the store.
- **Mid-flight reset:** assert rst=0 with 2 loads outstanding → all outputs 0 immediately. After release, a new load from requester 0 returns correctly and no stale response appears.
